// File: rtl/pc_scheduler_if.sv
// Sequencer-facing bundle: control inputs from decoder/fetcher/LSUs/PC units,
// plus the sequencer state outputs that every lane keys off.
interface pc_scheduler_if #(
  parameter int unsigned THREADS_PER_BLOCK     = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8
);
  logic                                               start;
  logic [THREADS_PER_BLOCK-1:0]                       thread_enable;
  logic                                               decoded_mem_read_enable;
  logic                                               decoded_mem_write_enable;
  logic                                               decoded_ret;
  logic [2:0]                                         fetcher_state;
  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state;
  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc;
  logic [2:0]                                         core_state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc;
  logic [THREADS_PER_BLOCK-1:0]                       active_mask;
  logic                                               done;

  modport master (
    output start, thread_enable, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    input  core_state, current_pc, active_mask, done
  );

  modport slave (
    input  start, thread_enable, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    output core_state, current_pc, active_mask, done
  );
endinterface

// File: rtl/pc_scheduler.sv
// Per-core instruction sequencer with min-PC reconvergence: after each
// instruction it issues only the live lanes sitting at the lowest next PC.
module pc_scheduler #(
  parameter int unsigned THREADS_PER_BLOCK     = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8
) (
  input logic          clk,
  input logic          reset,
  pc_scheduler_if.slave bus
);
  localparam int unsigned T = THREADS_PER_BLOCK;
  localparam int unsigned A = PROGRAM_MEM_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_DONE        = 2'b11;

  state_t       state_q;
  logic [A-1:0] pc_q;
  logic [T-1:0] mask_q;
  logic         done_q;
  logic [T-1:0] enable_q;
  logic [T-1:0] retired_q;

  logic [T-1:0] retired_n;
  logic [T-1:0] live;
  logic [A-1:0] min_pc;
  logic [T-1:0] issue_mask;
  logic         lsu_all_done;
  logic         mem_op;

  // Reconvergence selection and memory-completion detection
  always_comb begin
    retired_n    = retired_q | (bus.decoded_ret ? mask_q : T'(0));
    live         = enable_q & ~retired_n;
    min_pc       = '1;
    issue_mask   = '0;
    lsu_all_done = 1'b1;
    mem_op       = bus.decoded_mem_read_enable | bus.decoded_mem_write_enable;
    for (int i = 0; i < int'(T); i++) begin
      if (live[i] && (bus.next_pc[i*A +: A] < min_pc)) min_pc = bus.next_pc[i*A +: A];
    end
    for (int i = 0; i < int'(T); i++) begin
      issue_mask[i] = live[i] && (bus.next_pc[i*A +: A] == min_pc);
      if (mask_q[i] && (bus.lsu_state[2*i +: 2] != LSU_DONE)) lsu_all_done = 1'b0;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      enable_q  <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            enable_q  <= bus.thread_enable;
            retired_q <= '0;
            pc_q      <= '0;
            mask_q    <= bus.thread_enable;
            if (bus.thread_enable == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH:   if (bus.fetcher_state == FETCHER_FETCHED) state_q <= S_DECODE;
        S_DECODE:  state_q <= S_REQUEST;
        S_REQUEST: state_q <= S_WAIT;
        S_WAIT:    if (!mem_op || lsu_all_done) state_q <= S_EXECUTE;
        S_EXECUTE: state_q <= S_UPDATE;
        S_UPDATE: begin
          retired_q <= retired_n;
          if (live == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            mask_q  <= '0;
          end else begin
            pc_q    <= min_pc;
            mask_q  <= issue_mask;
            state_q <= S_FETCH;
          end
        end
        S_DONE:    done_q <= 1'b1;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.core_state  = state_q;
  assign bus.current_pc  = pc_q;
  assign bus.active_mask = mask_q;
  assign bus.done        = done_q;
endmodule

// File: doc/pc_scheduler.md
Name: pc_scheduler

Overview:
Per-core instruction sequencer with branch-divergence support. Drives the core_state that every lane's PC unit, ALU, LSU and the fetcher key off, and owns the shared current_pc. At each UPDATE it collects every lane's next_pc, selects the minimum PC among live lanes (min-PC reconvergence policy), and issues only the lanes at that PC via active_mask.

Parameters:
THREADS_PER_BLOCK, 4, number of lanes per core
PROGRAM_MEM_ADDR_BITS, 8, width of PCs

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch block execution (sampled in IDLE only)
thread_enable  in  THREADS_PER_BLOCK  lanes populated for this block
decoded_mem_read_enable  in  1  current instruction is LDR
decoded_mem_write_enable  in  1  current instruction is STR
decoded_ret  in  1  current instruction is RET
fetcher_state  in  3  fetcher FSM; 3'b010 = FETCHED
lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i]; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
next_pc  in  PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK  per-lane next PC, lane i at slice i
core_state  out  3  sequencer state
current_pc  out  PROGRAM_MEM_ADDR_BITS  PC of the instruction being issued
active_mask  out  THREADS_PER_BLOCK  lanes issued this instruction (gates PC/ALU/LSU/register enables)
done  out  1  all populated lanes have retired

Behaviour:
- Encodings: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Reset (async, any state, mid-instruction included): core_state=IDLE, current_pc=0, active_mask=0, done=0. Internal enable_q=0, retired=0.
- IDLE, start=1:
  - enable_q<=thread_enable, retired<=0, current_pc<=0, active_mask<=thread_enable.
  - Goes to FETCH, or to DONE if thread_enable==0.
  - thread_enable changes after start are ignored.
- FETCH: holds until fetcher_state==3'b010, then DECODE. No timeout.
- DECODE: one cycle, then REQUEST.
- REQUEST: one cycle (LSUs of active lanes leave IDLE in this cycle), then WAIT.
- WAIT:
  - If neither mem enable is set: go to EXECUTE after one cycle.
  - Otherwise: hold until lsu_state==11 for every lane in active_mask. Lanes outside active_mask are ignored.
- EXECUTE: one cycle, then UPDATE. PC units of active lanes compute next_pc in this cycle; next_pc is valid during UPDATE. Inactive lanes' next_pc holds its last value.
- UPDATE (single cycle):
  - retired_n = retired | (decoded_ret ? active_mask : 0). retired<=retired_n. live = enable_q & ~retired_n.
  - live==0: go to DONE, done<=1, active_mask<=0, current_pc holds.
  - Otherwise: m = unsigned minimum of next_pc over live lanes. current_pc<=m, active_mask<=live lanes with next_pc==m (all tied lanes issue together), then FETCH.
- DONE: done=1 and core_state=111 held; start ignored. Exit only via reset.
- Outputs are registered. active_mask never contains a retired or unpopulated lane. active_mask is nonzero in every state from FETCH to UPDATE.
- next_pc wrap (e.g. 255+1=0) is not special-cased; 0 wins the minimum.

Test Plan:
- Straight line: 4 lanes enabled, next_pc=current_pc+1 for all, RET at PC 3 → state sequence 001,010,011,100,101,110 per instruction; active_mask=1111 throughout; done=1 after 4th UPDATE; current_pc stays 3.
- Divergence: at PC 2, lanes 0,1 next_pc=5, lanes 2,3 next_pc=3 → current_pc=3, mask=1100. Lanes 2,3 reach 5 → mask=1111, current_pc=5.
- Memory wait: LDR with mask=0101; lane 0 DONE at cycle 2, lane 2 DONE at cycle 6, lanes 1/3 stuck at 01 → EXECUTE entered the cycle after lane 2 reaches 11.
- Partial retire: mask=0011 executes RET while lanes 2,3 wait at PC 7 → next issue current_pc=7, mask=1100; done only after their RET.
- Partial block: thread_enable=0010 → mask=0010 always; thread_enable=0000 with start → DONE directly, done=1.
- Async reset asserted mid-WAIT (between clock edges) → outputs immediately 000/0/0/0; a new start relaunches from PC 0.
